// File: rtl/core_pkg.sv
// Shared types and constants for the destination-side result pipeline.
//   stage_info_t : per-stage record (rd, wenb, load, csr, result)
//   BUBBLE       : empty stage contents (no write, no type flags)
//   X0           : hard-wired zero register index
//   ld_state_t   : status of the instruction currently in MEM with respect
//                  to outstanding load data
package core_pkg;

    localparam int unsigned CORE_XLEN = 32;

    localparam logic [4:0] X0 = 5'd0;

    typedef struct packed {
        logic [4:0]           rd;
        logic                 wenb;
        logic                 load;
        logic                 csr;
        logic [CORE_XLEN-1:0] result;
    } stage_info_t;

    localparam stage_info_t BUBBLE = '{
        rd:     X0,
        wenb:   1'b0,
        load:   1'b0,
        csr:    1'b0,
        result: '0
    };

    typedef enum logic [1:0] {
        LD_IDLE,   // MEM does not hold a load
        LD_WAIT,   // load in MEM, data not yet returned: freeze
        LD_DONE    // load in MEM, data valid this cycle: advance
    } ld_state_t;

    // x0 is never tracked as a written destination.
    function automatic logic wenb_capture(input logic       valid,
                                          input logic       wenb,
                                          input logic [4:0] rd);
        return valid & wenb & (rd != X0);
    endfunction

endpackage

// File: rtl/stage_reg.sv
// Pipeline stage register with freeze and bubble control.
//   clk, rst_n : clock, asynchronous active-low reset (clears to CLEAR_VAL)
//   hold       : keep current contents (wins over bubble)
//   bubble     : load CLEAR_VAL instead of d
//   d, q       : stage contents in / out
module stage_reg
    import core_pkg::*;
#(
    parameter type T         = stage_info_t,
    parameter T    CLEAR_VAL = BUBBLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic bubble,
    input  T     d,
    output T     q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= CLEAR_VAL;
        end else if (hold) begin
            q <= q;
        end else if (bubble) begin
            q <= CLEAR_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/rd_result_pipe.sv
// Destination-side pipeline tracker: carries rd / write-enable / type flags /
// result from DEC through EXE, MEM and WRB for the bypass/stall unit, drives
// the register-file write port, and freezes the pipe while a load in MEM
// waits for its data.
//   Inputs : clk, rst_n, dec_valid, dec_stall, pipe_flush, dec_rd,
//            dec_rd_wenb, dec_load, dec_csr, exe_alu_result, mem_csr_rdata,
//            dmem_rvalid, dmem_rdata
//   Outputs: exe/mem/wrb _rd, _rd_wenb, _result; exe_load, exe_csr;
//            pipe_hold; rf_wenb, rf_waddr, rf_wdata; hold_cycles
module rd_result_pipe
    import core_pkg::*;
#(
    parameter int unsigned XLEN = CORE_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            dec_valid,
    input  logic            dec_stall,
    input  logic            pipe_flush,
    input  logic [4:0]      dec_rd,
    input  logic            dec_rd_wenb,
    input  logic            dec_load,
    input  logic            dec_csr,
    input  logic [XLEN-1:0] exe_alu_result,
    input  logic [XLEN-1:0] mem_csr_rdata,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [4:0]      exe_rd,
    output logic [4:0]      mem_rd,
    output logic [4:0]      wrb_rd,
    output logic            exe_rd_wenb,
    output logic            mem_rd_wenb,
    output logic            wrb_rd_wenb,
    output logic [XLEN-1:0] exe_result,
    output logic [XLEN-1:0] mem_result,
    output logic [XLEN-1:0] wrb_result,
    output logic            exe_load,
    output logic            exe_csr,
    output logic            pipe_hold,
    output logic            rf_wenb,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     hold_cycles
);

    stage_info_t e_d, e_q;
    stage_info_t m_d, m_q;
    stage_info_t w_d, w_q;
    ld_state_t   ld_state;
    logic        e_bubble;

    // Load-wait status depends only on MEM contents and dmem_rvalid, so
    // pipe_hold has no combinational path from any dec_* input.
    always_comb begin
        ld_state = LD_IDLE;
        if (m_q.load) begin
            ld_state = dmem_rvalid ? LD_DONE : LD_WAIT;
        end
    end

    assign pipe_hold = (ld_state == LD_WAIT);

    // DEC -> EXE. Stall, flush and empty DEC all collapse to a bubble; the
    // stage register gives hold priority, so these are ignored while frozen.
    assign e_bubble = dec_stall | pipe_flush | ~dec_valid;

    always_comb begin
        e_d        = BUBBLE;
        e_d.rd     = dec_rd;
        e_d.wenb   = wenb_capture(dec_valid, dec_rd_wenb, dec_rd);
        e_d.load   = dec_load;
        e_d.csr    = dec_csr;
        e_d.result = '0;
    end

    // EXE -> MEM: the ALU result is only available combinationally in EXE.
    always_comb begin
        m_d        = e_q;
        m_d.result = exe_alu_result;
    end

    always_comb begin
        mem_result = m_q.result;
        if (m_q.load) begin
            mem_result = dmem_rdata;
        end else if (m_q.csr) begin
            mem_result = mem_csr_rdata;
        end
    end

    // MEM -> WRB takes the muxed result; WRB is refilled with a bubble while
    // MEM is frozen, so the stall never duplicates a register write.
    always_comb begin
        w_d        = m_q;
        w_d.result = mem_result;
    end

    stage_reg #(.T(stage_info_t), .CLEAR_VAL(BUBBLE)) u_exe_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (pipe_hold),
        .bubble (e_bubble),
        .d      (e_d),
        .q      (e_q)
    );

    stage_reg #(.T(stage_info_t), .CLEAR_VAL(BUBBLE)) u_mem_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (pipe_hold),
        .bubble (1'b0),
        .d      (m_d),
        .q      (m_q)
    );

    stage_reg #(.T(stage_info_t), .CLEAR_VAL(BUBBLE)) u_wrb_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (1'b0),
        .bubble (pipe_hold),
        .d      (w_d),
        .q      (w_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cycles <= '0;
        end else if (pipe_hold && (hold_cycles != '1)) begin
            hold_cycles <= hold_cycles + 32'd1;
        end
    end

    assign exe_rd      = e_q.rd;
    assign exe_rd_wenb = e_q.wenb;
    assign exe_load    = e_q.load;
    assign exe_csr     = e_q.csr;
    assign exe_result  = exe_alu_result;

    assign mem_rd      = m_q.rd;
    assign mem_rd_wenb = m_q.wenb;

    assign wrb_rd      = w_q.rd;
    assign wrb_rd_wenb = w_q.wenb;
    assign wrb_result  = w_q.result;

    assign rf_wenb     = w_q.wenb;
    assign rf_waddr    = w_q.rd;
    assign rf_wdata    = w_q.result;

    // Fields carried for a uniform stage record but never consumed here.
    logic unused_fields;
    assign unused_fields = ^{e_q.result, w_q.load, w_q.csr};

endmodule

// File: tb/tb_rd_result_pipe.sv
module tb_rd_result_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid, dec_stall, pipe_flush;
    logic [4:0]  dec_rd;
    logic        dec_rd_wenb, dec_load, dec_csr;
    logic [31:0] exe_alu_result, mem_csr_rdata, dmem_rdata;
    logic        dmem_rvalid;
    logic [4:0]  exe_rd, mem_rd, wrb_rd;
    logic        exe_rd_wenb, mem_rd_wenb, wrb_rd_wenb;
    logic [31:0] exe_result, mem_result, wrb_result;
    logic        exe_load, exe_csr, pipe_hold;
    logic        rf_wenb;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, hold_cycles;

    int checks   = 0;
    int failures = 0;
    bit check_en = 0;

    always #5 clk = ~clk;

    rd_result_pipe #(.XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dec_valid      (dec_valid),
        .dec_stall      (dec_stall),
        .pipe_flush     (pipe_flush),
        .dec_rd         (dec_rd),
        .dec_rd_wenb    (dec_rd_wenb),
        .dec_load       (dec_load),
        .dec_csr        (dec_csr),
        .exe_alu_result (exe_alu_result),
        .mem_csr_rdata  (mem_csr_rdata),
        .dmem_rvalid    (dmem_rvalid),
        .dmem_rdata     (dmem_rdata),
        .exe_rd         (exe_rd),
        .mem_rd         (mem_rd),
        .wrb_rd         (wrb_rd),
        .exe_rd_wenb    (exe_rd_wenb),
        .mem_rd_wenb    (mem_rd_wenb),
        .wrb_rd_wenb    (wrb_rd_wenb),
        .exe_result     (exe_result),
        .mem_result     (mem_result),
        .wrb_result     (wrb_result),
        .exe_load       (exe_load),
        .exe_csr        (exe_csr),
        .pipe_hold      (pipe_hold),
        .rf_wenb        (rf_wenb),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .hold_cycles    (hold_cycles)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: three instruction slots ----------
    typedef struct {
        int unsigned rd;
        bit          wenb;
        bit          load;
        bit          csr;
        int unsigned result;
    } slot_t;

    slot_t       me, mm, mw;
    int unsigned m_hold_cnt;

    function automatic slot_t empty_slot();
        slot_t s;
        s.rd = 0; s.wenb = 0; s.load = 0; s.csr = 0; s.result = 0;
        return s;
    endfunction

    function automatic int unsigned model_mem_result(slot_t s);
        if (s.load) return dmem_rdata;
        if (s.csr)  return mem_csr_rdata;
        return s.result;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            me = empty_slot(); mm = empty_slot(); mw = empty_slot();
            m_hold_cnt = 0;
        end else if (mm.load && !dmem_rvalid) begin
            mw = empty_slot();
            if (m_hold_cnt != 32'hFFFF_FFFF) m_hold_cnt = m_hold_cnt + 1;
        end else begin
            mw        = mm;
            mw.result = model_mem_result(mm);
            mm        = me;
            mm.result = exe_alu_result;
            if (dec_valid && !dec_stall && !pipe_flush) begin
                me.rd     = dec_rd;
                me.wenb   = dec_rd_wenb && (dec_rd != 0);
                me.load   = dec_load;
                me.csr    = dec_csr;
                me.result = 0;
            end else begin
                me = empty_slot();
            end
        end
    end

    // ---------------- per-cycle compare ----------------------------------
    always @(negedge clk) begin
        if (check_en && rst_n) begin
            bit hold_exp;
            hold_exp = mm.load && !dmem_rvalid;
            chk("exe_rd",      32'(exe_rd),      me.rd);
            chk("exe_rd_wenb", 32'(exe_rd_wenb), 32'(me.wenb));
            chk("exe_load",    32'(exe_load),    32'(me.load));
            chk("exe_csr",     32'(exe_csr),     32'(me.csr));
            chk("exe_result",  exe_result,       exe_alu_result);
            chk("mem_rd",      32'(mem_rd),      mm.rd);
            chk("mem_rd_wenb", 32'(mem_rd_wenb), 32'(mm.wenb));
            if (!hold_exp) chk("mem_result", mem_result, model_mem_result(mm));
            chk("wrb_rd",      32'(wrb_rd),      mw.rd);
            chk("wrb_rd_wenb", 32'(wrb_rd_wenb), 32'(mw.wenb));
            chk("wrb_result",  wrb_result,       mw.result);
            chk("rf_wenb",     32'(rf_wenb),     32'(mw.wenb));
            chk("rf_waddr",    32'(rf_waddr),    mw.rd);
            chk("rf_wdata",    rf_wdata,         mw.result);
            chk("pipe_hold",   32'(pipe_hold),   32'(hold_exp));
            chk("hold_cycles", hold_cycles,      m_hold_cnt);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dec_valid = 0; dec_stall = 0; pipe_flush = 0; dec_rd = 0;
        dec_rd_wenb = 0; dec_load = 0; dec_csr = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic wenb, input logic ld, input logic cs);
        dec_valid = 1; dec_stall = 0; pipe_flush = 0;
        dec_rd = rd; dec_rd_wenb = wenb; dec_load = ld; dec_csr = cs;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        exe_alu_result = 0; mem_csr_rdata = 0; dmem_rdata = 0; dmem_rvalid = 0;
        tick(); tick();
        rst_n = 1;
        check_en = 1;

        // reset state
        chk("rst_exe_rd", 32'(exe_rd), 0);
        chk("rst_rf_wenb", 32'(rf_wenb), 0);
        chk("rst_pipe_hold", 32'(pipe_hold), 0);
        chk("rst_hold_cycles", hold_cycles, 0);

        // ADD x5 -> result 0x1234, one stage per cycle
        issue(5, 1, 0, 0); exe_alu_result = 32'h1234;
        tick();
        chk("add_exe_rd", 32'(exe_rd), 5);
        chk("add_exe_wenb", 32'(exe_rd_wenb), 1);
        idle_inputs();
        tick();
        chk("add_mem_rd", 32'(mem_rd), 5);
        chk("add_mem_result", mem_result, 32'h1234);
        exe_alu_result = 32'h0;
        tick();
        chk("add_rf_wenb", 32'(rf_wenb), 1);
        chk("add_rf_waddr", 32'(rf_waddr), 5);
        chk("add_rf_wdata", rf_wdata, 32'h1234);

        // write to x0 is never tracked
        issue(0, 1, 0, 0);
        tick();
        chk("x0_exe_wenb", 32'(exe_rd_wenb), 0);
        idle_inputs();
        tick();
        chk("x0_mem_wenb", 32'(mem_rd_wenb), 0);
        tick();
        chk("x0_rf_wenb", 32'(rf_wenb), 0);

        // load x7, data three cycles late
        issue(7, 1, 1, 0);
        tick();
        chk("ld_exe_load", 32'(exe_load), 1);
        idle_inputs();
        tick();
        chk("ld_hold1", 32'(pipe_hold), 1);
        tick();
        chk("ld_hold2", 32'(pipe_hold), 1);
        chk("ld_mem_rd_frozen", 32'(mem_rd), 7);
        chk("ld_wrb_bubble", 32'(wrb_rd_wenb), 0);
        tick();
        chk("ld_hold3", 32'(pipe_hold), 1);
        tick();
        chk("ld_hold_cycles", hold_cycles, 3);
        dmem_rvalid = 1; dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_hold_release", 32'(pipe_hold), 0);
        chk("ld_mem_result", mem_result, 32'hDEADBEEF);
        tick();
        dmem_rvalid = 0;
        chk("ld_rf_wenb", 32'(rf_wenb), 1);
        chk("ld_rf_waddr", 32'(rf_waddr), 7);
        chk("ld_rf_wdata", rf_wdata, 32'hDEADBEEF);

        // two stall cycles behind a load in EXE, data arriving on time
        issue(8, 1, 1, 0);
        tick();
        issue(10, 1, 0, 0); dec_stall = 1;
        dmem_rvalid = 1; dmem_rdata = 32'h55;
        tick();
        chk("stall_exe_wenb1", 32'(exe_rd_wenb), 0);
        chk("stall_mem_rd", 32'(mem_rd), 8);
        tick();
        chk("stall_exe_wenb2", 32'(exe_rd_wenb), 0);
        chk("stall_rf_waddr", 32'(rf_waddr), 8);
        chk("stall_rf_wdata", rf_wdata, 32'h55);
        idle_inputs(); dmem_rvalid = 0;

        // CSR read into x3
        issue(3, 1, 0, 1);
        tick();
        chk("csr_exe_csr", 32'(exe_csr), 1);
        idle_inputs(); mem_csr_rdata = 32'hA5A5_0000;
        tick();
        chk("csr_mem_result", mem_result, 32'hA5A5_0000);
        tick();
        chk("csr_rf_waddr", 32'(rf_waddr), 3);
        chk("csr_rf_wdata", rf_wdata, 32'hA5A5_0000);

        // flushed x9 never reaches EXE
        issue(9, 1, 0, 0); pipe_flush = 1;
        tick();
        chk("flush_exe_rd", 32'(exe_rd), 0);
        chk("flush_exe_wenb", 32'(exe_rd_wenb), 0);
        idle_inputs();

        // reset in the middle of a load wait
        issue(7, 1, 1, 0);
        tick();
        idle_inputs();
        tick();
        tick();
        chk("rwait_hold", 32'(pipe_hold), 1);
        rst_n = 0;
        #1;
        chk("rwait_mem_rd", 32'(mem_rd), 0);
        chk("rwait_pipe_hold", 32'(pipe_hold), 0);
        chk("rwait_hold_cycles", hold_cycles, 0);
        chk("rwait_rf_wenb", 32'(rf_wenb), 0);
        dmem_rvalid = 1;
        tick();
        rst_n = 1;
        tick();
        chk("rwait_late_rvalid", 32'(mem_rd_wenb), 0);
        chk("rwait_no_hold", 32'(pipe_hold), 0);
        dmem_rvalid = 0;

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int unsigned kind;
            kind        = $urandom_range(0, 7);
            dec_valid   = ($urandom_range(0, 3) != 0);
            dec_stall   = ($urandom_range(0, 6) == 0);
            pipe_flush  = ($urandom_range(0, 9) == 0);
            dec_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            dec_rd_wenb = ($urandom_range(0, 4) != 0);
            dec_load    = (kind < 2);
            dec_csr     = (kind == 2);
            exe_alu_result = $urandom;
            mem_csr_rdata  = $urandom;
            dmem_rdata     = $urandom;
            dmem_rvalid    = ($urandom_range(0, 4) < 2);
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 0;
                tick();
                rst_n = 1;
            end
            tick();
        end

        idle_inputs();
        tick();
        check_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
